// File: rtl/grf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : grf_pkg
//  Description : Shared types, constants and helpers for the parametrised GRF.
//  Revision    : 1.0 - initial release
// ============================================================================
package grf_pkg;

    localparam int DROP_CNT_W = 16;
    localparam int TR_PC_W    = 32;
    localparam int TR_ADDR_W  = 5;
    localparam int TR_DATA_W  = 32;

    // Trace record layout for the default 32x32 configuration.
    typedef struct packed {
        logic [TR_PC_W-1:0]   pc;
        logic [TR_ADDR_W-1:0] addr;
        logic [TR_DATA_W-1:0] data;
    } trace_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/grf_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : grf_trace_fifo
//  Description : Show-ahead write-trace FIFO with saturating overflow counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_trace_fifo
    import grf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5,
    parameter int DEPTH  = 8,
    localparam int PW    = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [TR_PC_W-1:0]    i_pc,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_W-1:0]     i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [TR_PC_W-1:0]    o_pc,
    output logic [AW-1:0]         o_addr,
    output logic [DATA_W-1:0]     o_data,
    output logic [DROP_CNT_W-1:0] o_drops
);

    typedef struct packed {
        logic [TR_PC_W-1:0] pc;
        logic [AW-1:0]      addr;
        logic [DATA_W-1:0]  data;
    } entry_t;

    localparam logic [PW:0] C_DEPTH = (PW + 1)'(DEPTH);

    entry_t                r_mem [DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW:0]           r_count;
    logic [DROP_CNT_W-1:0] r_drops;

    logic   w_full;
    logic   w_pop;
    logic   w_wr;
    logic   w_drop;
    entry_t w_head;

    assign o_valid = (r_count != '0);
    assign w_full  = (r_count == C_DEPTH);
    assign w_pop   = o_valid && i_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr    = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drops <= '0;
        end else begin
            if (w_wr)  r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop && (r_drops != '1)) r_drops <= r_drops + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= '{pc: i_pc, addr: i_addr, data: i_data};
    end

    // Payload is forced to zero while empty so reset leaves clean outputs.
    assign w_head  = r_mem[r_rptr];
    assign o_pc    = o_valid ? w_head.pc   : '0;
    assign o_addr  = o_valid ? w_head.addr : '0;
    assign o_data  = o_valid ? w_head.data : '0;
    assign o_drops = r_drops;

endmodule
`default_nettype wire

// File: rtl/grf_param.sv
`default_nettype none
// ============================================================================
//  Module      : grf_param
//  Description : Parametrised MIPS register file with bypass and write trace.
//  Revision    : 1.0 - initial release
// ============================================================================
module grf_param
    import grf_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_REGS    = 32,
    parameter int RD_PORTS    = 2,
    parameter int BYPASS      = 1,
    parameter int TRACE_DEPTH = 8,
    localparam int AW         = clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [RD_PORTS*AW-1:0]     ra,
    output logic [RD_PORTS*DATA_W-1:0] rd,
    input  logic                       we,
    input  logic [AW-1:0]              wa,
    input  logic [DATA_W-1:0]          wd,
    input  logic [31:0]                pc,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [31:0]                trace_pc,
    output logic [AW-1:0]              trace_addr,
    output logic [DATA_W-1:0]          trace_data,
    output logic [DROP_CNT_W-1:0]      trace_drops
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr;

    // Writes to $0 neither update state nor leave a trace record.
    assign w_wr = we && (wa != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
            r_regs[wa] <= wd;
        end
    end

    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;

        assign w_ra = ra[g*AW +: AW];

        if (BYPASS != 0) begin : g_bypass
            assign w_hit = w_wr && (w_ra == wa);
        end else begin : g_no_bypass
            assign w_hit = 1'b0;
        end

        assign rd[g*DATA_W +: DATA_W] = (w_ra == '0) ? '0 :
                                        w_hit        ? wd : r_regs[w_ra];
    end

    grf_trace_fifo #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .DEPTH  (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_wr),
        .i_pc    (pc),
        .i_addr  (wa),
        .i_data  (wd),
        .i_ready (trace_ready),
        .o_valid (trace_valid),
        .o_pc    (trace_pc),
        .o_addr  (trace_addr),
        .o_data  (trace_data),
        .o_drops (trace_drops)
    );

endmodule
`default_nettype wire

// File: tb/tb_grf_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grf_param
//  Description : Scoreboard bench for grf_param (bypass and non-bypass copies).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_param;

    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [31:0]   pc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [2*AW-1:0] ra;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [31:0]   pc;
    logic          trace_ready;

    logic [2*DW-1:0] rd;
    logic            trace_valid;
    logic [31:0]     trace_pc;
    logic [AW-1:0]   trace_addr;
    logic [DW-1:0]   trace_data;
    logic [15:0]     trace_drops;

    logic [2*DW-1:0] nb_rd;
    logic            nb_trace_valid;
    logic [31:0]     nb_trace_pc;
    logic [AW-1:0]   nb_trace_addr;
    logic [DW-1:0]   nb_trace_data;
    logic [15:0]     nb_trace_drops;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];

    grf_param #(.DATA_W(DW), .NUM_REGS(32), .RD_PORTS(2), .BYPASS(1), .TRACE_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .ra(ra), .rd(rd), .we(we), .wa(wa), .wd(wd), .pc(pc),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_addr(trace_addr), .trace_data(trace_data), .trace_drops(trace_drops)
    );

    grf_param #(.DATA_W(DW), .NUM_REGS(32), .RD_PORTS(2), .BYPASS(0), .TRACE_DEPTH(8)) dut_nb (
        .clk(clk), .reset(reset), .ra(ra), .rd(nb_rd), .we(we), .wa(wa), .wd(wd), .pc(pc),
        .trace_valid(nb_trace_valid), .trace_ready(trace_ready), .trace_pc(nb_trace_pc),
        .trace_addr(nb_trace_addr), .trace_data(nb_trace_data), .trace_drops(nb_trace_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [31:0] p,
                      input bit expect_trace);
        we = 1'b1;
        wa = a;
        wd = d;
        pc = p;
        if (expect_trace) sb.push_back('{pc: p, addr: a, data: d});
    endtask

    // Monitor: whatever is presented with ready high is popped at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset && trace_valid && trace_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL trace_unexpected: got pc %0h addr %0h data %0h, expected none",
                         trace_pc, trace_addr, trace_data);
            end else begin
                e = sb.pop_front();
                chk("trace_pc",   64'(trace_pc),   64'(e.pc));
                chk("trace_addr", 64'(trace_addr), 64'(e.addr));
                chk("trace_data", 64'(trace_data), 64'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0; ra = '0; we = 1'b0; wa = '0; wd = '0; pc = '0; trace_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        ra = {5'd5, 5'd0};
        #1;
        chk("reset_rd0", 64'(rd[31:0]), 64'd0);
        chk("reset_rd1", 64'(rd[63:32]), 64'd0);
        chk("reset_valid", 64'(trace_valid), 64'd0);
        chk("reset_drops", 64'(trace_drops), 64'd0);
        chk("reset_trace_pc", 64'(trace_pc), 64'd0);
        reset = 1'b1;

        // Same-cycle bypass on both ports vs. non-bypass copy
        cyc();
        trace_ready = 1'b1;
        ra = {5'd28, 5'd28};
        wr(5'd28, 32'h1, 32'h3000, 1'b1);
        #1;
        chk("byp_rd0", 64'(rd[31:0]), 64'd1);
        chk("byp_rd1", 64'(rd[63:32]), 64'd1);
        chk("nobyp_rd0", 64'(nb_rd[31:0]), 64'd0);
        cyc();
        we = 1'b0;
        #1;
        chk("after_rd0", 64'(rd[31:0]), 64'd1);
        chk("nobyp_after_rd0", 64'(nb_rd[31:0]), 64'd1);

        // Write to $0 is discarded and untraced
        cyc();
        ra = {5'd0, 5'd0};
        wr(5'd0, 32'hDEADBEEF, 32'h3004, 1'b0);
        #1;
        chk("r0_byp_rd0", 64'(rd[31:0]), 64'd0);
        cyc();
        we = 1'b0;
        #1;
        chk("r0_rd0", 64'(rd[31:0]), 64'd0);
        chk("r0_no_trace", 64'(trace_valid), 64'd0);

        // Trace order under backpressure
        trace_ready = 1'b0;
        wr(5'd1, 32'd10, 32'h3000, 1'b1);
        cyc();
        wr(5'd2, 32'd20, 32'h3004, 1'b1);
        cyc();
        wr(5'd3, 32'd30, 32'h3008, 1'b1);
        cyc();
        we = 1'b0;
        ra = {5'd2, 5'd1};
        #1;
        chk("bp_valid", 64'(trace_valid), 64'd1);
        chk("bp_head_pc", 64'(trace_pc), 64'h3000);
        chk("bp_head_addr", 64'(trace_addr), 64'd1);
        chk("bp_head_data", 64'(trace_data), 64'd10);
        chk("bp_rd0", 64'(rd[31:0]), 64'd10);
        chk("bp_rd1", 64'(rd[63:32]), 64'd20);
        cyc();
        chk("bp_hold_pc", 64'(trace_pc), 64'h3000);
        chk("bp_hold_data", 64'(trace_data), 64'd10);
        trace_ready = 1'b1;
        for (int i = 0; i < 20 && (trace_valid || sb.size() != 0); i++) cyc();
        chk("drain_valid", 64'(trace_valid), 64'd0);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);

        // Overflow: first eight kept, two dropped
        trace_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr(AW'(i + 1), 32'(100 + i), 32'(32'h4000 + 4 * i), i < 8);
            cyc();
        end
        we = 1'b0;
        #1;
        chk("ovf_drops", 64'(trace_drops), 64'd2);
        chk("ovf_nb_drops", 64'(nb_trace_drops), 64'd2);
        chk("ovf_head_pc", 64'(trace_pc), 64'h4000);

        // Full push with simultaneous pop is not a drop
        trace_ready = 1'b1;
        wr(5'd11, 32'd111, 32'h4040, 1'b1);
        cyc();
        we = 1'b0;
        trace_ready = 1'b0;
        ra = {5'd11, 5'd1};
        #1;
        chk("fullpop_drops", 64'(trace_drops), 64'd2);
        chk("fullpop_valid", 64'(trace_valid), 64'd1);
        chk("fullpop_head_pc", 64'(trace_pc), 64'h4004);
        chk("pre_rst_rd0", 64'(rd[31:0]), 64'd100);
        chk("pre_rst_rd1", 64'(rd[63:32]), 64'd111);

        // Pop three, leaving five queued
        trace_ready = 1'b1;
        repeat (3) cyc();
        trace_ready = 1'b0;
        #1;
        chk("five_head_pc", 64'(trace_pc), 64'h4010);

        // Asynchronous reset between edges
        reset = 1'b0;
        sb.delete();
        #1;
        chk("arst_valid", 64'(trace_valid), 64'd0);
        chk("arst_rd0", 64'(rd[31:0]), 64'd0);
        chk("arst_rd1", 64'(rd[63:32]), 64'd0);
        chk("arst_drops", 64'(trace_drops), 64'd0);
        chk("arst_trace_pc", 64'(trace_pc), 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_valid", 64'(trace_valid), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
